// File: rtl/if_stage_fetch_if.sv
// Instruction-memory fetch channel: a valid/ready request carrying the fetch
// address and a single-cycle response pulse carrying the instruction word.
// Ports (master = fetch stage, slave = memory):
//   req_valid, addr : master -> slave   request and its word address
//   req_ready       : slave -> master   request accepted when valid & ready
//   rsp_valid       : slave -> master   one-cycle pulse with the word
//   rsp_data        : slave -> master   instruction word
interface if_stage_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one word fetch at a
// time over imem, and loads the IF/ID register consumed by decode.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   hazard_detected  freeze IF/ID; a word arriving meanwhile is parked
//   Br_taken         redirect from decode to Br_target, squashes IF/ID
//   imem             fetch channel (master side)
//   instruction, PC  IF/ID word and its address + PC_STEP
//   inst_valid       IF/ID holds a real instruction (0 = bubble)
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_detected,
    input  logic               Br_taken,
    input  logic [31:0]        Br_target,
    if_stage_fetch_if.master   imem,
    output logic [31:0]        instruction,
    output logic [31:0]        PC,
    output logic               inst_valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state, state_n;
    logic [31:0] fpc, fpc_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] hold_data, hold_data_n;
    logic [31:0] hold_addr, hold_addr_n;
    logic        deliver;
    logic [31:0] dlv_data;
    logic [31:0] dlv_pc;
    logic        hs;

    assign imem.req_valid = (state == S_FETCH) && !rst;
    assign imem.addr      = fpc;
    assign hs             = imem.req_valid && imem.req_ready;

    always_comb begin
        state_n     = state;
        fpc_n       = fpc;
        req_addr_n  = req_addr;
        hold_data_n = hold_data;
        hold_addr_n = hold_addr;
        deliver     = 1'b0;
        dlv_data    = NOP_WORD;
        dlv_pc      = PC;
        if (Br_taken) begin
            // A handshake completing alongside the redirect still leaves a
            // response in flight, so it must be drained in DROP.
            fpc_n = Br_target;
            unique case (state)
                S_FETCH: state_n = hs ? S_DROP : S_FETCH;
                S_WAIT:  state_n = imem.rsp_valid ? S_FETCH : S_DROP;
                S_HOLD:  state_n = S_FETCH;
                S_DROP:  state_n = imem.rsp_valid ? S_FETCH : S_DROP;
                default: state_n = S_FETCH;
            endcase
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (hs) begin
                        state_n    = S_WAIT;
                        req_addr_n = fpc;
                        fpc_n      = fpc + PC_STEP;
                    end
                end
                S_WAIT: begin
                    if (imem.rsp_valid) begin
                        if (hazard_detected) begin
                            hold_data_n = imem.rsp_data;
                            hold_addr_n = req_addr;
                            state_n     = S_HOLD;
                        end else begin
                            deliver  = 1'b1;
                            dlv_data = imem.rsp_data;
                            dlv_pc   = req_addr + PC_STEP;
                            state_n  = S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hazard_detected) begin
                        deliver  = 1'b1;
                        dlv_data = hold_data;
                        dlv_pc   = hold_addr + PC_STEP;
                        state_n  = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem.rsp_valid) begin
                        state_n = S_FETCH;
                    end
                end
                default: state_n = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            fpc         <= RESET_PC;
            req_addr    <= 32'h0;
            hold_data   <= 32'h0;
            hold_addr   <= 32'h0;
            instruction <= NOP_WORD;
            PC          <= 32'h0;
            inst_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            fpc       <= fpc_n;
            req_addr  <= req_addr_n;
            hold_data <= hold_data_n;
            hold_addr <= hold_addr_n;
            if (Br_taken) begin
                instruction <= NOP_WORD;
                inst_valid  <= 1'b0;
            end else if (hazard_detected) begin
                instruction <= instruction;
                PC          <= PC;
                inst_valid  <= inst_valid;
            end else if (deliver) begin
                instruction <= dlv_data;
                PC          <= dlv_pc;
                inst_valid  <= 1'b1;
            end else begin
                instruction <= NOP_WORD;
                inst_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: inputs change 1ns after a rising edge,
// outputs are checked there too, and the bench plays the memory by hand.
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        hazard_detected;
    logic        Br_taken;
    logic [31:0] Br_target;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic        inst_valid;
    int          checks;
    int          errors;

    if_stage_fetch_if imem();

    if_stage_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .Br_taken        (Br_taken),
        .Br_target       (Br_target),
        .imem            (imem),
        .instruction     (instruction),
        .PC              (PC),
        .inst_valid      (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hazard_detected = 1'b0;
        Br_taken = 1'b0;
        Br_target = 32'h0;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = 32'h0;
        step();
        step();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0h exp 0", imem.req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %0h exp 0", inst_valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction got %0h exp 0", instruction); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %0h exp 0", PC); end
        rst = 1'b0;
        #1;
        checks++; if (imem.req_valid !== 1'b1) begin errors++; $display("FAIL rst_rel_req_valid got %0h exp 1", imem.req_valid); end
        checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL rst_rel_addr got %0h exp 0", imem.addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            checks++; if (imem.req_valid !== 1'b1 || imem.addr !== a) begin errors++; $display("FAIL seq_req%0d got v%0h a%0h exp v1 a%0h", i, imem.req_valid, imem.addr, a); end
            step();
            checks++; if (inst_valid !== 1'b0 || imem.req_valid !== 1'b0) begin errors++; $display("FAIL seq_wait%0d got iv%0h rv%0h exp 0 0", i, inst_valid, imem.req_valid); end
            imem.rsp_valid = 1'b1;
            imem.rsp_data = word(a);
            step();
            imem.rsp_valid = 1'b0;
            checks++; if (inst_valid !== 1'b1 || instruction !== word(a) || PC !== a + 32'd4) begin errors++; $display("FAIL seq_ifid%0d got %0h %0h %0h exp 1 %0h %0h", i, inst_valid, instruction, PC, word(a), a + 32'd4); end
        end
    endtask

    task automatic test_hazard();
        hazard_detected = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || instruction !== word(32'h8) || PC !== 32'hC) begin errors++; $display("FAIL hz_freeze1 got %0h %0h %0h exp 1 %0h c", inst_valid, instruction, PC, word(32'h8)); end
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(32'hC);
        step();
        imem.rsp_valid = 1'b0;
        step();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL hz_hold_req got %0h exp 0", imem.req_valid); end
        checks++; if (inst_valid !== 1'b1 || instruction !== word(32'h8) || PC !== 32'hC) begin errors++; $display("FAIL hz_freeze3 got %0h %0h %0h exp 1 %0h c", inst_valid, instruction, PC, word(32'h8)); end
        hazard_detected = 1'b0;
        step();
        checks++; if (inst_valid !== 1'b1 || instruction !== word(32'hC) || PC !== 32'h10) begin errors++; $display("FAIL hz_release got %0h %0h %0h exp 1 %0h 10", inst_valid, instruction, PC, word(32'hC)); end
        checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 32'h10) begin errors++; $display("FAIL hz_next_req got %0h %0h exp 1 10", imem.req_valid, imem.addr); end
    endtask

    task automatic test_branch_wait();
        step();
        Br_taken = 1'b1;
        Br_target = 32'h100;
        step();
        Br_taken = 1'b0;
        checks++; if (imem.req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL brw_drop got rv%0h iv%0h exp 0 0", imem.req_valid, inst_valid); end
        step();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL brw_drop2 got %0h exp 0", imem.req_valid); end
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(32'h10);
        step();
        imem.rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL brw_stale got %0h %0h exp 0 0", inst_valid, instruction); end
        checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 32'h100) begin errors++; $display("FAIL brw_target got %0h %0h exp 1 100", imem.req_valid, imem.addr); end
        step();
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(32'h100);
        step();
        imem.rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || instruction !== word(32'h100) || PC !== 32'h104) begin errors++; $display("FAIL brw_ifid got %0h %0h %0h exp 1 %0h 104", inst_valid, instruction, PC, word(32'h100)); end
    endtask

    task automatic test_branch_accept();
        imem.req_ready = 1'b0;
        Br_taken = 1'b1;
        Br_target = 32'h8;
        step();
        checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 32'h8 || inst_valid !== 1'b0) begin errors++; $display("FAIL bra_redir got %0h %0h %0h exp 1 8 0", imem.req_valid, imem.addr, inst_valid); end
        imem.req_ready = 1'b1;
        Br_target = 32'h200;
        step();
        Br_taken = 1'b0;
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL bra_drop got %0h exp 0", imem.req_valid); end
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(32'h8);
        step();
        imem.rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || instruction !== 32'h0 || PC !== 32'h104) begin errors++; $display("FAIL bra_squash got %0h %0h %0h exp 0 0 104", inst_valid, instruction, PC); end
        checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 32'h200) begin errors++; $display("FAIL bra_fpc got %0h %0h exp 1 200", imem.req_valid, imem.addr); end
    endtask

    task automatic test_stall();
        imem.req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 32'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL stall%0d got %0h %0h %0h exp 1 200 0", i, imem.req_valid, imem.addr, inst_valid); end
        end
        imem.req_ready = 1'b1;
        step();
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(32'h200);
        step();
        imem.rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || instruction !== word(32'h200) || PC !== 32'h204) begin errors++; $display("FAIL stall_ifid got %0h %0h %0h exp 1 %0h 204", inst_valid, instruction, PC, word(32'h200)); end
    endtask

    task automatic test_reset_mid();
        step();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL rstm_wait got %0h exp 0", imem.req_valid); end
        rst = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b0 || instruction !== 32'h0 || PC !== 32'h0) begin errors++; $display("FAIL rstm_ifid got %0h %0h %0h exp 0 0 0", inst_valid, instruction, PC); end
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL rstm_req_in_rst got %0h exp 0", imem.req_valid); end
        rst = 1'b0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(32'h204);
        step();
        imem.rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL rstm_late got %0h %0h exp 0 0", inst_valid, instruction); end
        checks++; if (imem.req_valid !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL rstm_restart got %0h %0h exp 1 0", imem.req_valid, imem.addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_hazard();
        test_branch_wait();
        test_branch_accept();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
